// File: rtl/AHB_package.sv
// Shared AHB fabric types: burst encoding carried on hburst and on local commands.
`timescale 1ns/1ps
package AHB_package;
  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } hburst_type;
endpackage

// File: rtl/ahb_master_req_ctrl.sv
// Master-side AHB request/burst sequencer: takes one local burst command, requests the
// bus, then drives the pipelined address and data phases of the whole burst.
`timescale 1ns/1ps
module ahb_master_req_ctrl
  import AHB_package::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  hburst_type            cmd_burst,
  input  logic [4:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_data_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  hreq,
  input  logic                  hgrant,
  input  logic                  hwait,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output hburst_type            hburst,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic [DATA_WIDTH-1:0] hrdata
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_BURST, ST_DRAIN} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic                  write_reg;
  hburst_type            burst_reg;
  logic [4:0]            remain_reg;
  logic [4:0]            beats_reg;
  logic                  pending_reg;
  logic [DATA_WIDTH-1:0] hwdata_reg;
  logic [4:0]            cmd_beats;
  logic                  cmd_accept;
  logic                  addr_accept;
  logic                  last_beat;
  logic                  is_wrap;

  always_comb begin
    cmd_beats = 5'd1;
    case (cmd_burst)
      SINGLE:        cmd_beats = 5'd1;
      INCR: begin
        if (cmd_len == 5'd0)       cmd_beats = 5'd1;
        else if (cmd_len > 5'd16)  cmd_beats = 5'd16;
        else                       cmd_beats = cmd_len;
      end
      WRAP4, INCR4:   cmd_beats = 5'd4;
      WRAP8, INCR8:   cmd_beats = 5'd8;
      WRAP16, INCR16: cmd_beats = 5'd16;
      default:        cmd_beats = 5'd1;
    endcase
  end

  assign cmd_accept  = cmd_valid & cmd_ready;
  assign addr_accept = hgrant & ((state_reg == ST_REQ) | (state_reg == ST_BURST));
  assign last_beat   = (remain_reg == 5'd1);
  assign is_wrap     = (burst_reg == WRAP4) | (burst_reg == WRAP8) | (burst_reg == WRAP16);

  // An all-ones mask turns the wrap formula into a plain increment for INCR types.
  assign addr_inc  = addr_reg + ADDR_WIDTH'(BYTES);
  assign wrap_mask = is_wrap ? (ADDR_WIDTH'(beats_reg) * ADDR_WIDTH'(BYTES)) - ADDR_WIDTH'(1)
                             : '1;

  generate
    for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_next_addr
      assign addr_next[gi] = wrap_mask[gi] ? addr_inc[gi] : addr_reg[gi];
    end
  endgenerate

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) state_reg <= ST_IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (cmd_accept) state_next = ST_REQ;
      ST_REQ, ST_BURST: begin
        if (addr_accept) state_next = last_beat ? ST_DRAIN : ST_BURST;
      end
      ST_DRAIN: if (!hwait) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    hreq      = 1'b0;
    htrans    = TRANS_IDLE;
    done      = 1'b0;
    case (state_reg)
      ST_IDLE:  cmd_ready = 1'b1;
      ST_REQ: begin
        hreq   = 1'b1;
        htrans = TRANS_NONSEQ;
      end
      ST_BURST: begin
        hreq   = 1'b1;
        htrans = TRANS_SEQ;
      end
      ST_DRAIN: done = pending_reg & ~hwait;
      default:  cmd_ready = 1'b0;
    endcase
  end

  // The last accepted address stays on haddr; nothing past the burst is presented.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      addr_reg    <= '0;
      write_reg   <= 1'b0;
      burst_reg   <= SINGLE;
      remain_reg  <= 5'd0;
      beats_reg   <= 5'd0;
      pending_reg <= 1'b0;
      hwdata_reg  <= '0;
    end else begin
      if (cmd_accept) begin
        addr_reg   <= cmd_addr;
        write_reg  <= cmd_write;
        burst_reg  <= cmd_burst;
        remain_reg <= cmd_beats;
        beats_reg  <= cmd_beats;
      end
      if (addr_accept) begin
        remain_reg <= remain_reg - 5'd1;
        if (!last_beat) addr_reg <= addr_next;
        if (write_reg)  hwdata_reg <= wr_data;
      end
      if (addr_accept)  pending_reg <= 1'b1;
      else if (!hwait)  pending_reg <= 1'b0;
    end
  end

  assign haddr       = addr_reg;
  assign hwrite      = write_reg;
  assign hburst      = burst_reg;
  assign hwdata      = hwdata_reg;
  assign wr_data_ack = addr_accept & write_reg;
  assign rd_valid    = pending_reg & ~hwait & ~write_reg;
  assign rd_data     = hrdata;

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// Directed bench for ahb_master_req_ctrl: a per-cycle vector table for SINGLE/INCR4
// traffic plus hand-written burst sequences for wrap, stall, clamp and reset cases.
`timescale 1ns/1ps
module tb_ahb_master_req_ctrl;
  import AHB_package::*;

  logic        hclk;
  logic        hreset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  hburst_type  cmd_burst;
  logic [4:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_data_ack;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        hreq;
  logic        hgrant;
  logic        hwait;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  hburst_type  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata;

  ahb_master_req_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .hclk(hclk), .hreset_n(hreset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_burst(cmd_burst), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_data_ack(wr_data_ack), .rd_data(rd_data),
    .rd_valid(rd_valid), .done(done), .hreq(hreq), .hgrant(hgrant),
    .hwait(hwait), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic       cv;
    logic [31:0] addr;
    logic       wr;
    hburst_type burst;
    logic [4:0] len;
    logic [31:0] wdata;
    logic       grant;
    logic       hw;
    logic [31:0] rdata;
    logic       e_ready;
    logic       e_hreq;
    logic [1:0] e_trans;
    logic [31:0] e_haddr;
    logic       e_ack;
    logic       e_rv;
    logic       e_done;
    logic [31:0] e_hwdata;
  } vec_t;

  vec_t        tbl [14];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] acc_addr  [32];
  logic [1:0]  acc_trans [32];
  hburst_type  acc_burst;
  logic        acc_write;
  int          n_acc;
  int          n_done;
  int          n_stall;
  logic [31:0] wrap8_exp [8] = '{32'h38, 32'h3C, 32'h20, 32'h24,
                                 32'h28, 32'h2C, 32'h30, 32'h34};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic cv, input logic [31:0] a, input logic w,
                              input hburst_type b, input logic [4:0] l, input logic [31:0] wd,
                              input logic g, input logic hw, input logic [31:0] rd,
                              input logic er, input logic eq, input logic [1:0] et,
                              input logic [31:0] ea, input logic eack, input logic erv,
                              input logic edn, input logic [31:0] ewd);
    vec_t v;
    v.cv = cv; v.addr = a; v.wr = w; v.burst = b; v.len = l; v.wdata = wd;
    v.grant = g; v.hw = hw; v.rdata = rd;
    v.e_ready = er; v.e_hreq = eq; v.e_trans = et; v.e_haddr = ea;
    v.e_ack = eack; v.e_rv = erv; v.e_done = edn; v.e_hwdata = ewd;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_hreq"}, 32'(hreq), 32'd0);
    chk({tag, "_htrans"}, 32'(htrans), 32'd0);
    chk({tag, "_haddr"}, haddr, 32'd0);
    chk({tag, "_hwrite"}, 32'(hwrite), 32'd0);
    chk({tag, "_hburst"}, 32'(hburst), 32'(SINGLE));
    chk({tag, "_hwdata"}, hwdata, 32'd0);
    chk({tag, "_wr_data_ack"}, 32'(wr_data_ack), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Issue one command, then grant every cycle except a stall window; log accepted beats.
  task automatic run_burst(input logic [31:0] a, input logic w, input hburst_type b,
                           input logic [4:0] l, input int stall_at, input int stall_len,
                           input logic [31:0] stall_addr);
    logic timed_out;
    logic stall_now;
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_burst = b; cmd_len = l;
    hgrant = 1'b0; hwait = 1'b0;
    @(posedge hclk); #1;
    cmd_valid = 1'b0;
    n_acc = 0; n_done = 0; n_stall = 0; timed_out = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      stall_now = (n_acc == stall_at) && (n_stall < stall_len);
      hgrant  = ~stall_now;
      wr_data = 32'hC0DE_0000 + 32'(n_acc);
      #4;
      if (stall_now) begin
        n_stall++;
        chk("stall_haddr", haddr, stall_addr);
        chk("stall_htrans", 32'(htrans), 32'd3);
        chk("stall_hreq", 32'(hreq), 32'd1);
      end
      if (hgrant && htrans != 2'b00 && n_acc < 32) begin
        if (n_acc == 0) begin
          acc_burst = hburst;
          acc_write = hwrite;
        end
        acc_addr[n_acc]  = haddr;
        acc_trans[n_acc] = htrans;
        n_acc++;
      end
      if (done) n_done++;
      @(posedge hclk); #1;
      if (n_done > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    hgrant = 1'b0;
    chk("burst_timeout", 32'(timed_out), 32'd0);
    chk("burst_done_count", 32'(n_done), 32'd1);
    $display("burst addr=0x%0h type=%0d: %0d beats accepted", a, b, n_acc);
  endtask

  initial begin
    hreset_n = 1'b0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_burst = SINGLE; cmd_len = '0;
    wr_data = '0; hgrant = 1'b0; hwait = 1'b0; hrdata = '0;

    // SINGLE write at 0x100, then INCR4 read at 0x40 with a 2-cycle wait on beat 2
    // and one extra wait cycle in DRAIN.
    tbl[0]  = mk(1, 32'h100, 1, SINGLE, 0, 32'hA5A50001, 0, 0, 0,      1, 0, 2'b00, 32'h0,   0, 0, 0, 32'h0);
    tbl[1]  = mk(0, 32'h100, 1, SINGLE, 0, 32'hA5A50001, 0, 0, 0,      0, 1, 2'b10, 32'h100, 0, 0, 0, 32'h0);
    tbl[2]  = mk(0, 32'h100, 1, SINGLE, 0, 32'hA5A50001, 1, 0, 0,      0, 1, 2'b10, 32'h100, 1, 0, 0, 32'h0);
    tbl[3]  = mk(0, 32'h100, 1, SINGLE, 0, 32'h0,        0, 0, 0,      0, 0, 2'b00, 32'h100, 0, 0, 1, 32'hA5A50001);
    tbl[4]  = mk(1, 32'h40,  0, INCR4,  0, 32'hDEAD0000, 0, 0, 0,      1, 0, 2'b00, 32'h100, 0, 0, 0, 32'hA5A50001);
    tbl[5]  = mk(0, 32'h40,  0, INCR4,  0, 32'hDEAD0000, 1, 0, 0,      0, 1, 2'b10, 32'h40,  0, 0, 0, 32'hA5A50001);
    tbl[6]  = mk(0, 32'h40,  0, INCR4,  0, 32'hDEAD0000, 1, 0, 32'h1111, 0, 1, 2'b11, 32'h44, 0, 1, 0, 32'hA5A50001);
    tbl[7]  = mk(0, 32'h40,  0, INCR4,  0, 32'hDEAD0000, 0, 1, 0,      0, 1, 2'b11, 32'h48,  0, 0, 0, 32'hA5A50001);
    tbl[8]  = mk(0, 32'h40,  0, INCR4,  0, 32'hDEAD0000, 0, 1, 0,      0, 1, 2'b11, 32'h48,  0, 0, 0, 32'hA5A50001);
    tbl[9]  = mk(0, 32'h40,  0, INCR4,  0, 32'hDEAD0000, 1, 0, 32'h2222, 0, 1, 2'b11, 32'h48, 0, 1, 0, 32'hA5A50001);
    tbl[10] = mk(0, 32'h40,  0, INCR4,  0, 32'hDEAD0000, 1, 0, 32'h3333, 0, 1, 2'b11, 32'h4C, 0, 1, 0, 32'hA5A50001);
    tbl[11] = mk(0, 32'h40,  0, INCR4,  0, 32'hDEAD0000, 0, 1, 0,      0, 0, 2'b00, 32'h4C,  0, 0, 0, 32'hA5A50001);
    tbl[12] = mk(0, 32'h40,  0, INCR4,  0, 32'hDEAD0000, 0, 0, 32'h4444, 0, 0, 2'b00, 32'h4C, 0, 1, 1, 32'hA5A50001);
    tbl[13] = mk(0, 32'h40,  0, INCR4,  0, 32'hDEAD0000, 0, 0, 0,      1, 0, 2'b00, 32'h4C,  0, 0, 0, 32'hA5A50001);

    #2;
    check_reset_outputs("reset");
    #10 hreset_n = 1'b1;
    @(posedge hclk); #1;

    for (int i = 0; i < 14; i++) begin
      cmd_valid = tbl[i].cv; cmd_addr = tbl[i].addr; cmd_write = tbl[i].wr;
      cmd_burst = tbl[i].burst; cmd_len = tbl[i].len; wr_data = tbl[i].wdata;
      hgrant = tbl[i].grant; hwait = tbl[i].hw; hrdata = tbl[i].rdata;
      #4;
      chk($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'(tbl[i].e_ready));
      chk($sformatf("v%0d_hreq", i), 32'(hreq), 32'(tbl[i].e_hreq));
      chk($sformatf("v%0d_htrans", i), 32'(htrans), 32'(tbl[i].e_trans));
      chk($sformatf("v%0d_haddr", i), haddr, tbl[i].e_haddr);
      chk($sformatf("v%0d_wr_data_ack", i), 32'(wr_data_ack), 32'(tbl[i].e_ack));
      chk($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].e_rv));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("v%0d_hwdata", i), hwdata, tbl[i].e_hwdata);
      if (tbl[i].e_rv) chk($sformatf("v%0d_rd_data", i), rd_data, tbl[i].rdata);
      $display("vector %0d: haddr=0x%0h htrans=%0d hreq=%0d done=%0d", i, haddr, htrans, hreq, done);
      @(posedge hclk); #1;
    end
    cmd_valid = 1'b0; hwait = 1'b0; hgrant = 1'b0;

    // WRAP8 at 0x38 wraps at the 32-byte boundary.
    run_burst(32'h38, 1'b0, WRAP8, 5'd0, -1, 0, 32'h0);
    chk("wrap8_beats", 32'(n_acc), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wrap8_addr%0d", i), acc_addr[i], wrap8_exp[i]);
      chk($sformatf("wrap8_trans%0d", i), 32'(acc_trans[i]), (i == 0) ? 32'd2 : 32'd3);
    end
    chk("wrap8_hburst", 32'(acc_burst), 32'(WRAP8));
    chk("wrap8_hwrite", 32'(acc_write), 32'd0);

    // INCR8 with a 3-cycle grant gap after the third accept: address frozen at 0x20C.
    run_burst(32'h200, 1'b0, INCR8, 5'd0, 3, 3, 32'h20C);
    chk("stall_cycles", 32'(n_stall), 32'd3);
    chk("stall_beats", 32'(n_acc), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("stall_addr%0d", i), acc_addr[i], 32'h200 + 32'(4 * i));

    // INCR length clamping.
    run_burst(32'h300, 1'b1, INCR, 5'd0, -1, 0, 32'h0);
    chk("len0_beats", 32'(n_acc), 32'd1);
    chk("len0_trans", 32'(acc_trans[0]), 32'd2);
    chk("len0_hwrite", 32'(acc_write), 32'd1);
    chk("len0_hwdata", hwdata, 32'hC0DE_0000);
    run_burst(32'h300, 1'b0, INCR, 5'd20, -1, 0, 32'h0);
    chk("len20_beats", 32'(n_acc), 32'd16);
    chk("len20_last_addr", acc_addr[15], 32'h33C);
    chk("len20_last_trans", 32'(acc_trans[15]), 32'd3);

    // Reset asserted mid-cycle during beat 3 of an INCR16 write.
    cmd_valid = 1'b1; cmd_addr = 32'h400; cmd_write = 1'b1; cmd_burst = INCR16; cmd_len = 5'd0;
    @(posedge hclk); #1;
    cmd_valid = 1'b0; hgrant = 1'b1;
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    chk("rst_pre_haddr", haddr, 32'h408);
    chk("rst_pre_htrans", 32'(htrans), 32'd3);
    #2 hreset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge hclk); #1;
    chk("rst_hold_done", 32'(done), 32'd0);
    hgrant = 1'b0;
    #3 hreset_n = 1'b1;
    @(posedge hclk); #1;
    check_reset_outputs("rst_post");
    for (int i = 0; i < 4; i++) begin
      @(posedge hclk); #1;
      chk($sformatf("rst_idle%0d_done", i), 32'(done), 32'd0);
      chk($sformatf("rst_idle%0d_hreq", i), 32'(hreq), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ahb_master_req_ctrl.md
# ahb_master_req_ctrl

Master-side request and burst sequencer for the generated AHB fabric. It is the requesting end of the per-slave arbiter handshake:
- Accepts one local burst command at a time.
- Raises `hreq` toward the arbiter and waits for `hgrant`.
- Drives the pipelined address and data phases of the whole burst with a correct `htrans` and address sequence.
- Holds `hburst` stable so the arbiter's beat monitor counts the same burst length.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width; bytes per beat `BYTES` = `DATA_WIDTH`/8; single transfer size only.

Ports:
- `hclk`  in  1  clock; all logic on rising edge.
- `hreset_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  local command strobe.
- `cmd_ready`  out  1  high in IDLE only; a command is accepted when `cmd_valid` & `cmd_ready`.
- `cmd_addr`  in  `ADDR_WIDTH`  start address, `BYTES`-aligned.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_burst`  in  `hburst_type`  burst type (from `AHB_package`).
- `cmd_len`  in  5  beat count, used for INCR only.
- `wr_data`  in  `DATA_WIDTH`  write data for the beat whose address is being accepted.
- `wr_data_ack`  out  1  `wr_data` consumed this cycle.
- `rd_data`  out  `DATA_WIDTH`  equals `hrdata`.
- `rd_valid`  out  1  read beat completes this cycle.
- `done`  out  1  one-cycle pulse when the final data phase completes.
- `hreq`  out  1  request to the arbiter.
- `hgrant`  in  1  grant from the arbiter; already qualified with ~`hwait`.
- `hwait`  in  1  slave wait; data phase stalls while high.
- `haddr`  out  `ADDR_WIDTH`  address.
- `htrans`  out  2  IDLE=2'b00, NONSEQ=2'b10, SEQ=2'b11; BUSY is never issued.
- `hwrite`  out  1  transfer direction.
- `hburst`  out  `hburst_type`  burst type.
- `hwdata`  out  `DATA_WIDTH`  write data.
- `hrdata`  in  `DATA_WIDTH`  read data.

## Operation
States: IDLE, REQ, BURST, DRAIN.
- **IDLE:**
  - `cmd_ready` = 1, `hreq` = 0, `htrans` = IDLE.
  - On accept, latch addr, write, burst and beat count, then go to REQ.
  - Beat count: SINGLE 1; INCR uses `cmd_len` (0 is treated as 1, values >16 are clamped to 16); WRAP4/INCR4 4; WRAP8/INCR8 8; WRAP16/INCR16 16.
- **REQ:**
  - `hreq` = 1, `htrans` = NONSEQ, `haddr` = start address.
  - An address is accepted on any edge where `hgrant` = 1.
  - On accept: if beat count is 1, go to DRAIN; otherwise go to BURST.
- **BURST:**
  - `hreq` = 1, `htrans` = SEQ.
  - Each accepting edge advances `haddr` and decrements the remaining count.
  - After the last address is accepted, go to DRAIN.
  - While `hgrant` = 0, `haddr`/`htrans`/`hburst` hold.
- **DRAIN:**
  - `hreq` = 0, `htrans` = IDLE.
  - Wait for the final data phase to complete (`hwait` = 0), then pulse `done` and go to IDLE.
- **Address arithmetic:**
  - INCR types: next = addr + `BYTES`.
  - WRAP types: mask = beats×`BYTES`−1; next = (addr & ~mask) | ((addr+`BYTES`) & mask).
- **Data phase:**
  - A pending flag is set on every address accept. It clears on a cycle with `hwait` = 0 and no new accept.
  - Because `hgrant` implies `hwait` = 0, every accept also completes the previous data phase.
- **Write:**
  - `wr_data_ack` = address accept & `hwrite` (combinational).
  - `hwdata` registers `wr_data` on accept and holds through the data phase.
- **Read:**
  - `rd_valid` = pending & ~`hwait` & ~`hwrite`.
- `hwrite` and `hburst` stay constant from REQ through DRAIN.

## Timing
- **Reset values:**
  - `hreq` 0, `htrans` IDLE, `haddr` 0, `hwrite` 0, `hburst` SINGLE, `hwdata` 0.
  - `cmd_ready` 1, `wr_data_ack` 0, `rd_valid` 0, `done` 0.
- **Reset mid-burst:** all outputs return to reset values immediately, the command is dropped, and no `done` is issued.
- **Latency:**
  - Accept at edge N gives `hreq` = 1 from cycle N+1.
  - The first address is accepted at the first edge with `hgrant` = 1.
  - `done` comes no earlier than 1 cycle after the last address accept.
- **Back-to-back:** the next command is accepted no earlier than the cycle after `done`, and `hreq` drops for at least one cycle between bursts.
- **hwait:** while high, the current data phase extends and `hwdata` holds; `rd_valid` stays 0.
- **WRAP16:** the boundary at 16×`BYTES` wraps exactly once per burst.

## Test plan
- **SINGLE write:** write to 0x100, `hgrant` one cycle after `hreq` → one NONSEQ at 0x100, `hwdata` = `wr_data` next cycle, `done` pulses, `hreq` low in DRAIN.
- **INCR4 read with waits:** INCR4 read at 0x40, `hwait` = 1 for 2 cycles on beat 2 → addresses 0x40/44/48/4C, NONSEQ then 3 SEQ, 4 `rd_valid` pulses, address held during the wait.
- **WRAP8 wrap-around:** WRAP8 at 0x38 (32-bit) → addresses 0x38,0x3C,0x20,0x24,0x28,0x2C,0x30,0x34.
- **Grant stall:** `hgrant` drops for 3 cycles mid INCR8 → `haddr`/`htrans` frozen, `hreq` stays 1, and the burst resumes at the correct address.
- **INCR length clamp:** INCR with `cmd_len` = 0 → exactly one NONSEQ; with `cmd_len` = 20 → 16 beats.
- **Reset mid-burst:** assert `hreset_n` low during beat 3 of INCR16 → all outputs at reset values asynchronously, no `done`, and `cmd_ready` = 1 after release.
